// File: rtl/alu_op_sequencer.sv
// Sweep sequencer for the 4-bit ALU: latches one operand pair, issues opcodes 0..7
// over a valid/ready channel and records each response (or a timeout) per opcode.
module alu_op_sequencer #(
  parameter int DATA_W  = 4,
  parameter int RES_W   = 5,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [DATA_W-1:0] req_a,
  output logic [DATA_W-1:0] req_b,
  output logic [2:0]        req_op,
  input  logic              rsp_valid,
  input  logic [RES_W-1:0]  rsp_result,
  output logic              busy,
  output logic              done,
  output logic [7:0]        to_flags,
  input  logic [2:0]        rd_idx,
  output logic [RES_W-1:0]  rd_data
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [2:0]              op_q, op_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [DATA_W-1:0]       a_q, a_d;
  logic [DATA_W-1:0]       b_q, b_d;
  logic [7:0]              flags_q, flags_d;
  logic [7:0][RES_W-1:0]   res_q, res_d;
  logic                    stepDone;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    timer_d  = timer_q;
    a_d      = a_q;
    b_d      = b_q;
    flags_d  = flags_q;
    res_d    = res_q;
    stepDone = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          flags_d = '0;
          op_d    = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (req_ready) begin
          timer_d = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        // A response arriving on the expiry cycle takes priority over the timeout.
        if (rsp_valid) begin
          res_d[op_q] = rsp_result;
          stepDone    = 1'b1;
        end else if (timer_q == TMAX) begin
          res_d[op_q]   = '1;
          flags_d[op_q] = 1'b1;
          stepDone      = 1'b1;
        end
        if (stepDone) begin
          if (op_q == 3'd7) begin
            state_d = S_DONE;
          end else begin
            op_d    = op_q + 3'd1;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      timer_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      flags_q <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      timer_q <= timer_d;
      a_q     <= a_d;
      b_q     <= b_d;
      flags_q <= flags_d;
      res_q   <= res_d;
    end
  end

  assign req_valid = (state_q == S_ISSUE);
  assign busy      = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign done      = (state_q == S_DONE);
  assign req_a     = a_q;
  assign req_b     = b_q;
  assign req_op    = op_q;
  assign to_flags  = flags_q;
  // Plain read of the stored file; a write in this cycle shows up next cycle.
  assign rd_data   = res_q[rd_idx];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a scripted ALU responder plus a sweep-level model
// (expected opcode order, latency and per-opcode results) checked every cycle.
module tb_alu_op_sequencer;

  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a_in, b_in;
  logic       req_valid, req_ready;
  logic [3:0] req_a, req_b;
  logic [2:0] req_op;
  logic       rsp_valid;
  logic [4:0] rsp_result;
  logic       busy, done;
  logic [7:0] to_flags;
  logic [2:0] rd_idx;
  logic [4:0] rd_data;

  alu_op_sequencer #(.DATA_W(4), .RES_W(5), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
    .busy(busy), .done(done), .to_flags(to_flags), .rd_idx(rd_idx), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int stallOp = -1;
  int stallLeft = 0;
  int silentOp = -1;
  int lateOp = -1;
  bit autoResp = 1'b1;
  bit inWait = 1'b0;
  int waitCyc = 0;
  int wOp = 0;
  logic [3:0] wA = '0, wB = '0;

  bit sweepActive = 1'b0;
  bit doneSeen = 1'b0;
  int expOp = 0;
  logic [3:0] expA = '0, expB = '0;
  int startEdge = 0;
  int expLat = 17;

  // Reference ALU: mul, add, sub, div, mod, shl, shr, greater-than; 5-bit results.
  function automatic logic [4:0] aluRef(input logic [3:0] a, input logic [3:0] b, input int k);
    int ai, bi, r;
    ai = int'(a);
    bi = int'(b);
    case (k)
      0: r = ai * bi;
      1: r = ai + bi;
      2: r = ai - bi;
      3: r = (bi != 0) ? ai / bi : 0;
      4: r = (bi != 0) ? ai % bi : 0;
      5: r = ai * 2;
      6: r = ai / 2;
      default: r = (ai > bi) ? 1 : 0;
    endcase
    return r[4:0];
  endfunction

  function automatic logic [4:0] expRes(input logic [3:0] a, input logic [3:0] b, input int k);
    if (k == silentOp) return 5'h1F;
    if (k == lateOp) return 5'd9;
    return aluRef(a, b, k);
  endfunction

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic compareCycle();
    if (sweepActive) begin
      if (req_valid) begin
        checkOutput("req_a", int'(req_a), int'(expA));
        checkOutput("req_b", int'(req_b), int'(expB));
        checkOutput("req_op", int'(req_op), expOp);
      end
      if (done) begin
        checkOutput("done_op_count", expOp, 8);
        checkOutput("done_latency", cyc - startEdge + 1, expLat);
        checkOutput("busy_in_done", int'(busy), 0);
        doneSeen = 1'b1;
        sweepActive = 1'b0;
      end else begin
        checkOutput("busy_in_sweep", int'(busy), 1);
      end
      if (req_valid && req_ready) expOp++;
    end else begin
      checkOutput("idle_busy", int'(busy), 0);
      checkOutput("idle_req_valid", int'(req_valid), 0);
      checkOutput("idle_done", int'(done), 0);
    end
  endtask

  // One clock: compare at the falling edge, then drive responder inputs 1ns after the rising edge.
  task automatic applyStimulus();
    bit hs;
    logic [2:0] hsOp;
    logic [3:0] hsA, hsB;
    @(negedge clk);
    compareCycle();
    hs = req_valid && req_ready;
    hsOp = req_op;
    hsA = req_a;
    hsB = req_b;
    @(posedge clk);
    cyc++;
    #1;
    if (autoResp) begin
      rsp_valid = 1'b0;
      rsp_result = '0;
      if (hs) begin
        inWait = 1'b1;
        waitCyc = 1;
        wOp = int'(hsOp);
        wA = hsA;
        wB = hsB;
      end else if (inWait) begin
        waitCyc++;
      end
      if (inWait) begin
        if (wOp == silentOp) begin
          if (waitCyc >= TIMEOUT) inWait = 1'b0;
        end else if (wOp == lateOp) begin
          if (waitCyc == TIMEOUT) begin
            rsp_valid = 1'b1;
            rsp_result = 5'd9;
            inWait = 1'b0;
          end
        end else begin
          rsp_valid = 1'b1;
          rsp_result = aluRef(wA, wB, wOp);
          inWait = 1'b0;
        end
      end
      req_ready = 1'b1;
      if (req_valid && int'(req_op) == stallOp && stallLeft > 0) begin
        req_ready = 1'b0;
        stallLeft--;
      end
    end
  endtask

  task automatic startSweep(input logic [3:0] a, input logic [3:0] b, input int lat);
    a_in = a;
    b_in = b;
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    startEdge = cyc;
    expA = a;
    expB = b;
    expOp = 0;
    expLat = lat;
    doneSeen = 1'b0;
    sweepActive = 1'b1;
  endtask

  task automatic waitDone();
    for (int i = 0; i < 400 && !doneSeen; i++) applyStimulus();
    checkOutput("done_seen", int'(doneSeen), 1);
    sweepActive = 1'b0;
  endtask

  task automatic checkResults(input logic [3:0] a, input logic [3:0] b);
    int expF;
    for (int k = 0; k < 8; k++) begin
      rd_idx = 3'(k);
      #1;
      checkOutput($sformatf("res[%0d]", k), int'(rd_data), int'(expRes(a, b, k)));
      applyStimulus();
    end
    expF = (silentOp >= 0) ? (1 << silentOp) : 0;
    checkOutput("to_flags", int'(to_flags), expF);
  endtask

  task automatic checkAllZero(input string tag);
    for (int k = 0; k < 8; k++) begin
      rd_idx = 3'(k);
      #1;
      checkOutput($sformatf("%s_res[%0d]", tag, k), int'(rd_data), 0);
      applyStimulus();
    end
    checkOutput({tag, "_to_flags"}, int'(to_flags), 0);
  endtask

  initial begin
    int lit[8];
    lit = '{12, 7, 1, 1, 1, 8, 2, 1};
    rst = 1'b1;
    start = 1'b0;
    a_in = '0;
    b_in = '0;
    req_ready = 1'b1;
    rsp_valid = 1'b0;
    rsp_result = '0;
    rd_idx = '0;
    @(posedge clk);
    #1;
    repeat (3) applyStimulus();
    rst = 1'b0;

    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_req_valid", int'(req_valid), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_req_a", int'(req_a), 0);
    checkOutput("rst_req_b", int'(req_b), 0);
    checkOutput("rst_req_op", int'(req_op), 0);
    checkAllZero("rst");

    $display("[TB] scenario 1: zero-wait sweep 4/3");
    startSweep(4'd4, 4'd3, 17);
    waitDone();
    for (int k = 0; k < 8; k++) begin
      rd_idx = 3'(k);
      #1;
      checkOutput($sformatf("s1_literal[%0d]", k), int'(rd_data), lit[k]);
      applyStimulus();
    end
    checkResults(4'd4, 4'd3);

    $display("[TB] scenario 2: backpressure on op 2");
    stallOp = 2;
    stallLeft = 3;
    startSweep(4'd4, 4'd3, 17 + 3);
    waitDone();
    stallOp = -1;
    checkResults(4'd4, 4'd3);

    $display("[TB] scenario 3: silent responder on op 5");
    silentOp = 5;
    startSweep(4'd4, 4'd3, 17 + TIMEOUT - 1);
    waitDone();
    checkOutput("s3_flags_literal", int'(to_flags), 32);
    rd_idx = 3'd5;
    #1;
    checkOutput("s3_res5_literal", int'(rd_data), 31);
    applyStimulus();
    checkResults(4'd4, 4'd3);
    silentOp = -1;

    $display("[TB] scenario 4: response on the expiry cycle of op 3");
    lateOp = 3;
    startSweep(4'd4, 4'd3, 17 + TIMEOUT - 1);
    waitDone();
    checkResults(4'd4, 4'd3);
    lateOp = -1;

    $display("[TB] scenario 5: reset while waiting on op 4");
    silentOp = 4;
    startSweep(4'd4, 4'd3, 17 + TIMEOUT - 1);
    for (int i = 0; i < 100 && expOp < 5; i++) applyStimulus();
    checkOutput("s5_reached_op4_wait", expOp, 5);
    repeat (3) applyStimulus();
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    sweepActive = 1'b0;
    inWait = 1'b0;
    silentOp = -1;
    checkOutput("s5_busy", int'(busy), 0);
    checkOutput("s5_req_valid", int'(req_valid), 0);
    checkOutput("s5_req_op", int'(req_op), 0);
    checkOutput("s5_req_a", int'(req_a), 0);
    checkAllZero("s5_after_rst");
    autoResp = 1'b0;
    rsp_valid = 1'b1;
    rsp_result = 5'd10;
    applyStimulus();
    rsp_valid = 1'b0;
    rsp_result = '0;
    applyStimulus();
    autoResp = 1'b1;
    checkAllZero("s5_late_rsp");

    $display("[TB] scenario 6: start re-pulsed while busy");
    startSweep(4'd4, 4'd3, 17);
    a_in = 4'd9;
    b_in = 4'd9;
    start = 1'b1;
    waitDone();
    start = 1'b0;
    checkResults(4'd4, 4'd3);
    startSweep(4'd9, 4'd9, 17);
    waitDone();
    checkResults(4'd9, 4'd9);
    rd_idx = 3'd7;
    #1;
    checkOutput("s6_op7_literal", int'(rd_data), 0);
    rd_idx = 3'd0;
    #1;
    checkOutput("s6_op0_literal", int'(rd_data), 17);
    applyStimulus();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Initiator-side companion to the team's 4-bit, 8-opcode ALU.
- On `start`, latches one operand pair and issues all 8 opcodes (0..7) in order over a valid/ready request channel.
- Collects each 5-bit response into an 8-entry result file indexed by opcode, with per-opcode timeout detection.
- Sits between test/control logic and any ALU responder; used for self-test sweeps and bring-up.

Parameters:
- DATA_W, 4, operand width.
- RES_W, 5, result width.
- TIMEOUT, 16, max cycles waited for a response per opcode (must be >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- a_in  input  DATA_W  operand A, latched on accepted start.
- b_in  input  DATA_W  operand B, latched on accepted start.
- req_valid  output  1  request valid.
- req_ready  input  1  responder accepts request.
- req_a  output  DATA_W  latched operand A.
- req_b  output  DATA_W  latched operand B.
- req_op  output  3  current opcode.
- rsp_valid  input  1  response valid (single-cycle strobe).
- rsp_result  input  RES_W  response data.
- busy  output  1  high in ISSUE and WAIT.
- done  output  1  one-cycle pulse at end of sweep.
- to_flags  output  8  bit k set if opcode k timed out in the last sweep.
- rd_idx  input  3  result-file read index.
- rd_data  output  RES_W  combinational read, res[rd_idx].

Behaviour:
- Clock and reset: single clock `clk`; `rst` is synchronous and active-high.
- Reset values:
  - State = IDLE.
  - req_valid, busy, done = 0.
  - req_a, req_b, req_op = 0.
  - to_flags = 0.
  - All 8 result entries = 0.
  - Internal timer = 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - start=1 latches a_in/b_in, clears to_flags, sets op=0, and goes to ISSUE next cycle.
  - The result file is not cleared; entries are overwritten during the sweep.
- ISSUE:
  - req_valid=1.
  - req_a/req_b/req_op are held stable until the handshake.
  - On req_valid & req_ready, go to WAIT and set timer=0.
  - req_ready low stalls indefinitely; there is no timeout in ISSUE.
- WAIT:
  - req_valid=0; timer increments each cycle.
  - If rsp_valid: res[op] <= rsp_result.
  - Else if timer == TIMEOUT-1: res[op] <= all-ones (5'h1F) and to_flags[op] <= 1.
  - rsp_valid in the same cycle as timer expiry: the response wins, and the flag is not set.
  - After either event: if op==7 go to DONE, else op <= op+1 and go to ISSUE.
  - There is no wrap to op 0 within a sweep.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 in DONE.
- Ignored inputs:
  - rsp_valid outside WAIT, including the handshake cycle itself; the earliest accepted response is one cycle after the handshake.
  - start outside IDLE, including in DONE.
- Timing:
  - Minimum sweep with zero-wait responder: handshake cycle + response cycle per op = 16 cycles from the first ISSUE.
  - done asserts on cycle 17 after the start-accept edge.
- rd_data:
  - Combinational from the result file at all times, including mid-sweep.
  - A same-cycle write is not bypassed; the new value is visible next cycle.
- Reset mid-sweep:
  - Returns to IDLE next edge with all reset values.
  - Any in-flight response is dropped.

Test Plan:
1. Zero-wait responder, a_in=4, b_in=3, start pulse -> req_op 0..7 in order. res = {12,7,1,1,1,8,2,1} for ops 0..7. to_flags=0; done pulses once, 17 cycles after start.
2. Backpressure: req_ready low for 3 cycles at op=2 -> req_valid held high with req_a=4, req_b=3, req_op=2 stable. Results identical to scenario 1.
3. Responder silent on op 5 only, TIMEOUT=16 -> res[5]=5'h1F and to_flags=8'b0010_0000 after 16 WAIT cycles. Other entries match scenario 1.
4. rsp_valid asserted with result 9 on exactly the expiry cycle of op 3 -> res[3]=9 and to_flags[3]=0.
5. rst asserted during WAIT at op 4 -> next cycle: IDLE, busy=0, req_valid=0, to_flags=0, all res=0. A late rsp_valid is ignored.
6. start re-pulsed with a_in=9, b_in=9 while busy -> ignored; req_a stays 4. A new start in IDLE after done latches 9/9, and op 7 (a>b) returns 0.
